// File: rtl/synth_cfg_pkg.sv
// Shared constants, FSM state encoding and config payload for the synth configuration controller.
package synth_cfg_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned INSTR_W = 6;
    localparam int unsigned MUTE_W  = 3;
    localparam int unsigned ECHO_W  = 3;
    localparam int unsigned VOICE_W = 2;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned OFF_W   = 10;

    localparam logic [KEY_W-1:0] KEY_MUTE       = 4'h0;
    localparam logic [KEY_W-1:0] KEY_VOICE0     = 4'h1;
    localparam logic [KEY_W-1:0] KEY_VOICE1     = 4'h2;
    localparam logic [KEY_W-1:0] KEY_VOICE2     = 4'h3;
    localparam logic [KEY_W-1:0] KEY_INSTR_BASE = 4'h4;
    localparam logic [KEY_W-1:0] KEY_INSTR_LAST = 4'h7;
    localparam logic [KEY_W-1:0] KEY_ECHO_UP    = 4'hA;
    localparam logic [KEY_W-1:0] KEY_ECHO_DN    = 4'hB;
    localparam logic [KEY_W-1:0] KEY_DEFAULT    = 4'hC;

    localparam logic [ECHO_W-1:0] ECHO_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [MUTE_W-1:0]  mute;
        logic [ECHO_W-1:0]  echo;
    } cfg_s;

    localparam cfg_s                CFG_DEFAULT   = '{instr: '0, mute: '0, echo: '0};
    localparam logic [VOICE_W-1:0]  VOICE_DEFAULT = 2'd0;

endpackage

// File: rtl/synth_cfg_ctrl_key_cmd_decode.sv
// Keypad command decoder: owns the shadow config, the selected voice and the dirty flag.
module key_cmd_decode
    import synth_cfg_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               commit,
    output cfg_s               shadow_next_c,
    output logic               cmd_c,
    output logic [VOICE_W-1:0] sel_voice,
    output logic               dirty
);

    cfg_s               shadow;
    logic [VOICE_W-1:0] sel_next_c;
    logic [VOICE_W-1:0] vidx_c;

    // Next shadow: the current key merged on top of the stored shadow.
    always_comb begin
        shadow_next_c = shadow;
        sel_next_c    = sel_voice;
        cmd_c         = 1'b0;
        vidx_c        = VOICE_W'(key_code - KEY_VOICE0);
        if (key_valid) begin
            case (key_code)
                KEY_MUTE: begin
                    shadow_next_c.mute[sel_voice] = ~shadow.mute[sel_voice];
                    cmd_c = 1'b1;
                end
                KEY_VOICE0, KEY_VOICE1, KEY_VOICE2: begin
                    if (32'(vidx_c) < NUM_VOICES) begin
                        sel_next_c = vidx_c;
                        cmd_c      = 1'b1;
                    end
                end
                KEY_ECHO_UP: begin
                    if (shadow.echo != ECHO_MAX)
                        shadow_next_c.echo = shadow.echo + ECHO_W'(1);
                    cmd_c = 1'b1;
                end
                KEY_ECHO_DN: begin
                    if (shadow.echo != '0)
                        shadow_next_c.echo = shadow.echo - ECHO_W'(1);
                    cmd_c = 1'b1;
                end
                KEY_DEFAULT: begin
                    shadow_next_c = CFG_DEFAULT;
                    sel_next_c    = VOICE_DEFAULT;
                    cmd_c         = 1'b1;
                end
                default: begin
                    if (key_code >= KEY_INSTR_BASE && key_code <= KEY_INSTR_LAST) begin
                        shadow_next_c.instr[{sel_voice, 1'b0} +: 2] = 2'(key_code - KEY_INSTR_BASE);
                        cmd_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // A commit consumes everything merged so far, including a key in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= CFG_DEFAULT;
            sel_voice <= VOICE_DEFAULT;
            dirty     <= 1'b0;
        end else begin
            shadow    <= shadow_next_c;
            sel_voice <= sel_next_c;
            if (commit)
                dirty <= 1'b0;
            else if (cmd_c)
                dirty <= 1'b1;
        end
    end

endmodule

// File: rtl/synth_cfg_ctrl.sv
// Configuration controller: frame-aligned commit of keypad settings with req/ack to the player.
module synth_cfg_ctrl
    import synth_cfg_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned NUM_VOICES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic [POS_W-1:0]   enc_pos,
    input  logic               new_frame,
    input  logic               cfg_ack,
    output logic [INSTR_W-1:0] instr_cfg,
    output logic [MUTE_W-1:0]  mute,
    output logic [ECHO_W-1:0]  echo_level,
    output logic [VOICE_W-1:0] sel_voice,
    output logic               cfg_req,
    output logic               busy,
    output logic               ack_err,
    output logic [OFF_W-1:0]   disp_off0,
    output logic [OFF_W-1:0]   disp_off1,
    output logic [OFF_W-1:0]   disp_off2
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    cfg_state_e         state;
    logic [CNT_W-1:0]   tmo_cnt;
    cfg_s               shadow_next_c;
    logic               cmd_c;
    logic               dirty;
    logic               commit_c;
    logic               timeout_c;
    logic [OFF_W-1:0]   pos_base_c;

    assign commit_c   = (state == PEND) && new_frame;
    assign timeout_c  = (tmo_cnt == CNT_W'(ACK_TIMEOUT));
    assign pos_base_c = OFF_W'({enc_pos, 2'b00});

    key_cmd_decode #(
        .NUM_VOICES (NUM_VOICES)
    ) u_decode (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .commit        (commit_c),
        .shadow_next_c (shadow_next_c),
        .cmd_c         (cmd_c),
        .sel_voice     (sel_voice),
        .dirty         (dirty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            instr_cfg  <= '0;
            mute       <= '0;
            echo_level <= '0;
            cfg_req    <= 1'b0;
            busy       <= 1'b0;
            ack_err    <= 1'b0;
            disp_off0  <= '0;
            disp_off1  <= '0;
            disp_off2  <= '0;
        end else begin
            disp_off0 <= pos_base_c;
            disp_off1 <= pos_base_c << 1;
            disp_off2 <= pos_base_c << 2;

            // A timeout in the same cycle as key C still leaves the error flagged.
            if (key_valid && key_code == KEY_DEFAULT)
                ack_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_c) begin
                        state <= PEND;
                        busy  <= 1'b1;
                    end
                end
                PEND: begin
                    if (new_frame) begin
                        instr_cfg  <= shadow_next_c.instr;
                        mute       <= shadow_next_c.mute;
                        echo_level <= shadow_next_c.echo;
                        cfg_req    <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (cfg_ack || timeout_c) begin
                        cfg_req <= 1'b0;
                        if (!cfg_ack)
                            ack_err <= 1'b1;
                        if (dirty || cmd_c) begin
                            state <= PEND;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synth_cfg_ctrl.sv
// Directed self-checking bench for synth_cfg_ctrl with a short ack timeout.
module tb_synth_cfg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [4:0] enc_pos;
    logic       new_frame;
    logic       cfg_ack;
    logic [5:0] instr_cfg;
    logic [2:0] mute;
    logic [2:0] echo_level;
    logic [1:0] sel_voice;
    logic       cfg_req;
    logic       busy;
    logic       ack_err;
    logic [9:0] disp_off0;
    logic [9:0] disp_off1;
    logic [9:0] disp_off2;

    int checks = 0;
    int errors = 0;

    synth_cfg_ctrl #(
        .ACK_TIMEOUT (4),
        .NUM_VOICES  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .enc_pos    (enc_pos),
        .new_frame  (new_frame),
        .cfg_ack    (cfg_ack),
        .instr_cfg  (instr_cfg),
        .mute       (mute),
        .echo_level (echo_level),
        .sel_voice  (sel_voice),
        .cfg_req    (cfg_req),
        .busy       (busy),
        .ack_err    (ack_err),
        .disp_off0  (disp_off0),
        .disp_off1  (disp_off1),
        .disp_off2  (disp_off2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic ack();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int high_cycles;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        enc_pos   = 5'd0;
        new_frame = 1'b0;
        cfg_ack   = 1'b0;
        tick();
        tick();
        check("rst_instr", 32'(instr_cfg), 32'd0);
        check("rst_mute", 32'(mute), 32'd0);
        check("rst_echo", 32'(echo_level), 32'd0);
        check("rst_req_busy_err", {29'd0, cfg_req, busy, ack_err}, 32'd0);
        check("rst_disp2", 32'(disp_off2), 32'd0);
        reset = 1'b0;

        // Ack outside APPLY is ignored
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        check("ack_idle", {30'd0, cfg_req, busy}, 32'd0);

        // Voice 1, instrument 1, commit, ack
        press(4'h2);
        check("sel_v1", 32'(sel_voice), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        press(4'h5);
        check("live_hold", 32'(instr_cfg), 32'd0);
        check("req_before_frame", 32'(cfg_req), 32'd0);
        frame();
        check("instr_commit", 32'(instr_cfg), 32'b000100);
        check("req_rise", 32'(cfg_req), 32'd1);
        ack();
        check("req_fall_ack", 32'(cfg_req), 32'd0);
        check("busy_fall_ack", 32'(busy), 32'd0);
        check("no_err_ack", 32'(ack_err), 32'd0);

        // Echo saturation both ways
        for (int i = 0; i < 8; i++) press(4'hA);
        check("echo_pre_commit", 32'(echo_level), 32'd0);
        frame();
        check("echo_sat_hi", 32'(echo_level), 32'd7);
        ack();
        for (int i = 0; i < 10; i++) press(4'hB);
        frame();
        check("echo_sat_lo", 32'(echo_level), 32'd0);
        check("instr_kept", 32'(instr_cfg), 32'b000100);
        ack();

        // Key together with frame in IDLE: commit only on a later frame
        do_reset();
        key_valid = 1'b1;
        key_code  = 4'h0;
        new_frame = 1'b1;
        tick();
        key_valid = 1'b0;
        new_frame = 1'b0;
        check("kf_no_commit_req", 32'(cfg_req), 32'd0);
        check("kf_no_commit_mute", 32'(mute), 32'd0);
        check("kf_busy", 32'(busy), 32'd1);
        frame();
        check("kf_mute", 32'(mute), 32'b001);

        // No ack: cfg_req stays high ACK_TIMEOUT+1 cycles
        high_cycles = 0;
        while (cfg_req && high_cycles < 20) begin
            high_cycles++;
            tick();
        end
        check("tmo_req_cycles", 32'(high_cycles), 32'd5);
        check("tmo_err", 32'(ack_err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);

        // Key C clears the error and commits defaults
        press(4'hC);
        check("c_err_clr", 32'(ack_err), 32'd0);
        frame();
        check("c_mute_default", 32'(mute), 32'd0);
        check("c_req", 32'(cfg_req), 32'd1);
        ack();

        // Commands during APPLY lead back to PEND
        press(4'h5);
        frame();
        check("apply_instr0", 32'(instr_cfg), 32'b000001);
        press(4'h3);
        press(4'h6);
        check("apply_sel", 32'(sel_voice), 32'd2);
        check("apply_live_hold", 32'(instr_cfg), 32'b000001);
        ack();
        check("dirty_req", 32'(cfg_req), 32'd0);
        check("dirty_busy", 32'(busy), 32'd1);
        frame();
        check("dirty_commit", 32'(instr_cfg), 32'b100001);
        check("dirty_req_rise", 32'(cfg_req), 32'd1);

        // Asynchronous reset mid-APPLY
        reset = 1'b1;
        #1;
        check("arst_req", 32'(cfg_req), 32'd0);
        check("arst_instr", 32'(instr_cfg), 32'd0);
        check("arst_busy_sel", {30'd0, busy, sel_voice != 2'd0}, 32'd0);
        tick();
        reset = 1'b0;
        frame();
        check("arst_no_commit", 32'(cfg_req), 32'd0);

        // Display offsets
        enc_pos = 5'd31;
        tick();
        check("disp0_31", 32'(disp_off0), 32'd124);
        check("disp1_31", 32'(disp_off1), 32'd248);
        check("disp2_31", 32'(disp_off2), 32'd496);
        enc_pos = 5'd3;
        tick();
        check("disp2_3", 32'(disp_off2), 32'd48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
